// File: rtl/crc_pkg.sv
// Shared constants, state encoding and per-kind helpers for the CRC transmit framer.
// A frame kind selects the data width, the generator polynomial and the codeword byte count.
package crc_pkg;

    localparam int unsigned DATA_W = 20;
    localparam int unsigned REM_W  = 10;
    localparam int unsigned CW_W   = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned IDX_W  = 2;

    localparam logic [1:0] KIND8    = 2'd0;
    localparam logic [1:0] KIND16   = 2'd1;
    localparam logic [1:0] KIND_BAD = 2'd2;
    localparam logic [1:0] KIND20   = 2'd3;

    // Generators are stored without their x^r term; that term only drives the feedback.
    localparam logic [REM_W-1:0] G8_LO  = 10'h003;
    localparam logic [REM_W-1:0] G16_LO = 10'h007;
    localparam logic [REM_W-1:0] G20_LO = 10'h233;

    localparam logic [CNT_W-1:0] N8  = 5'd8;
    localparam logic [CNT_W-1:0] N16 = 5'd16;
    localparam logic [CNT_W-1:0] N20 = 5'd20;

    localparam logic [IDX_W-1:0] LAST8  = 2'd1;
    localparam logic [IDX_W-1:0] LAST16 = 2'd2;
    localparam logic [IDX_W-1:0] LAST20 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CRC  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic kind_legal(input logic [1:0] k);
        return k != KIND_BAD;
    endfunction

    function automatic logic [CNT_W-1:0] kind_nbits(input logic [1:0] k);
        case (k)
            KIND8:   return N8;
            KIND16:  return N16;
            default: return N20;
        endcase
    endfunction

    function automatic logic [REM_W-1:0] kind_poly(input logic [1:0] k);
        case (k)
            KIND8:   return G8_LO;
            KIND16:  return G16_LO;
            default: return G20_LO;
        endcase
    endfunction

    function automatic logic [REM_W-1:0] kind_rmask(input logic [1:0] k);
        case (k)
            KIND8:   return 10'h00F;
            KIND16:  return 10'h0FF;
            default: return 10'h3FF;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] kind_dmask(input logic [1:0] k);
        case (k)
            KIND8:   return 20'h000FF;
            KIND16:  return 20'h0FFFF;
            default: return 20'hFFFFF;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] kind_last_byte(input logic [1:0] k);
        case (k)
            KIND8:   return LAST8;
            KIND16:  return LAST16;
            default: return LAST20;
        endcase
    endfunction

    // Codeword left-justified into 32 bits; unused low bits are zero padding.
    function automatic logic [CW_W-1:0] cw_align(input logic [1:0] k,
                                                 input logic [DATA_W-1:0] d,
                                                 input logic [REM_W-1:0] r);
        case (k)
            KIND8:   return {d[7:0], r[3:0], 20'h00000};
            KIND16:  return {d[15:0], r[7:0], 8'h00};
            default: return {d, r, 2'b00};
        endcase
    endfunction

    function automatic logic [BYTE_W-1:0] cw_byte(input logic [CW_W-1:0] cw,
                                                  input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    return cw[31:24];
            2'd1:    return cw[23:16];
            2'd2:    return cw[15:8];
            default: return cw[7:0];
        endcase
    endfunction

endpackage

// File: rtl/crc_frame_tx_lfsr.sv
// Bit-serial CRC remainder engine, sized for the widest generator and masked to the active degree.
module crc_serial_lfsr
    import crc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [1:0]       kind,
    output logic [REM_W-1:0] rem
);

    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] rem_d;
    logic             msb_c;
    logic             fb_c;

    // Feedback tap sits at bit r-1 of the active degree.
    always_comb begin
        case (kind)
            KIND8:   msb_c = rem_q[3];
            KIND16:  msb_c = rem_q[7];
            default: msb_c = rem_q[9];
        endcase
        fb_c  = bit_in ^ msb_c;
        rem_d = rem_q;
        if (clear) begin
            rem_d = '0;
        end else if (shift_en) begin
            rem_d = ((rem_q << 1) ^ (fb_c ? kind_poly(kind) : '0)) & kind_rmask(kind);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem = rem_q;

endmodule

// File: rtl/crc_frame_tx.sv
// Transmit CRC framer: latches one data word, computes its remainder bit-serially,
// then streams the left-justified codeword MSB-first over a valid/ready byte interface.
module crc_frame_tx
    import crc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        kind,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              done,
    output logic              err_kind
);

    state_e              state_q;
    logic [1:0]          kind_q;
    logic [DATA_W-1:0]   data_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [IDX_W-1:0]    byte_idx_q;
    logic                busy_q;
    logic [BYTE_W-1:0]   byte_out_q;
    logic                byte_valid_q;
    logic                done_q;
    logic                err_kind_q;

    logic                accept_c;
    logic                shift_c;
    logic [CNT_W-1:0]    bit_last_c;
    logic [CNT_W-1:0]    bit_idx_c;
    logic                bit_in_c;
    logic [REM_W-1:0]    rem;
    logic [CW_W-1:0]     cw_c;

    always_comb begin
        accept_c   = (state_q == IDLE) && start && kind_legal(kind);
        shift_c    = (state_q == CRC);
        bit_last_c = kind_nbits(kind_q) - 5'd1;
        bit_idx_c  = bit_last_c - bit_cnt_q;
        bit_in_c   = data_q[bit_idx_c];
        cw_c       = cw_align(kind_q, data_q, rem);
    end

    crc_serial_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept_c),
        .shift_en (shift_c),
        .bit_in   (bit_in_c),
        .kind     (kind_q),
        .rem      (rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            kind_q       <= KIND8;
            data_q       <= '0;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            busy_q       <= 1'b0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_kind_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            err_kind_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (!kind_legal(kind)) begin
                            err_kind_q <= 1'b1;
                        end else begin
                            kind_q     <= kind;
                            data_q     <= data & kind_dmask(kind);
                            bit_cnt_q  <= '0;
                            byte_idx_q <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= CRC;
                        end
                    end
                end
                CRC: begin
                    if (bit_cnt_q == bit_last_c) begin
                        state_q <= EMIT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                end
                EMIT: begin
                    // First EMIT cycle loads byte 0 from the settled remainder.
                    if (!byte_valid_q) begin
                        byte_out_q   <= cw_byte(cw_c, byte_idx_q);
                        byte_valid_q <= 1'b1;
                    end else if (byte_ready) begin
                        if (byte_idx_q == kind_last_byte(kind_q)) begin
                            byte_valid_q <= 1'b0;
                            byte_out_q   <= '0;
                            done_q       <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            byte_out_q <= cw_byte(cw_c, byte_idx_q + 2'd1);
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign done       = done_q;
    assign err_kind   = err_kind_q;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Self-checking bench for crc_frame_tx: directed vector table, hand-written corner sequences
// and random frames checked against a polynomial long-division reference model.
module tb_crc_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  kind = 2'd0;
    logic [19:0] data = '0;
    logic        busy;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        done;
    logic        err_kind;

    int checks = 0;
    int errors = 0;

    crc_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .kind       (kind),
        .data       (data),
        .busy       (busy),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .done       (done),
        .err_kind   (err_kind)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  k;
        logic [19:0] d;
        logic [31:0] exp_cw;
        int          mode;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int k_n(input logic [1:0] k);
        return (k == 2'd0) ? 8 : (k == 2'd1) ? 16 : 20;
    endfunction

    function automatic int k_r(input logic [1:0] k);
        return (k == 2'd0) ? 4 : (k == 2'd1) ? 8 : 10;
    endfunction

    function automatic logic [63:0] k_g(input logic [1:0] k);
        return (k == 2'd0) ? 64'h13 : (k == 2'd1) ? 64'h107 : 64'h633;
    endfunction

    // GF(2) polynomial long division: remainder of v (degree < top) by g of degree r.
    function automatic logic [63:0] poly_mod(input logic [63:0] v, input int top,
                                             input logic [63:0] g, input int r);
        logic [63:0] x;
        x = v;
        for (int i = top - 1; i >= r; i--) begin
            if (x[i]) x = x ^ (g << (i - r));
        end
        return x;
    endfunction

    function automatic logic [31:0] model_cw(input logic [1:0] k, input logic [19:0] d);
        int n, r, t;
        logic [63:0] dd, rem, cw;
        n   = k_n(k);
        r   = k_r(k);
        t   = n + r;
        dd  = 64'(d) & ((64'd1 << n) - 64'd1);
        rem = poly_mod(dd << r, t, k_g(k), r);
        cw  = (dd << r) | rem;
        return 32'(cw << (32 - t));
    endfunction

    // mode 0: ready tied high; 1: ready pattern 1,0,0 per valid cycle; 2: random ready plus stray starts.
    task automatic do_frame(input logic [1:0] k, input logic [19:0] d, input logic [31:0] exp_cw,
                            input int mode, input string tag);
        int n, nb, t, c, got, vcnt, first_c;
        logic [31:0] coll;
        logic bad_busy, bad_err, bad_done;
        n  = k_n(k);
        t  = n + k_r(k);
        nb = (t + 7) / 8;
        start = 1'b1; kind = k; data = d; byte_ready = 1'b0;
        tick();
        start = 1'b0;
        kind = 2'($urandom);
        data = 20'($urandom);
        c = 0; got = 0; vcnt = 0; first_c = -1; coll = '0;
        bad_busy = 1'b0; bad_err = 1'b0; bad_done = 1'b0;
        while (got < nb && c < 400) begin
            case (mode)
                0:       byte_ready = 1'b1;
                1:       byte_ready = (vcnt % 3) == 0;
                default: begin
                    byte_ready = 1'($urandom);
                    start = ($urandom % 4) == 0;
                    kind  = 2'($urandom);
                end
            endcase
            if (busy !== 1'b1) bad_busy = 1'b1;
            if (err_kind !== 1'b0) bad_err = 1'b1;
            if (done !== 1'b0) bad_done = 1'b1;
            if (byte_valid === 1'b1) begin
                if (first_c < 0) begin
                    first_c = c;
                    chk({tag, "_first_valid_lat"}, 32'(c), 32'(n + 1));
                end
                chk($sformatf("%s_byte%0d", tag, got), 32'(byte_out), 32'(exp_cw[31 - 8*got -: 8]));
                if (byte_ready) begin
                    coll[31 - 8*got -: 8] = byte_out;
                    got++;
                end
                vcnt++;
            end
            tick();
            c++;
        end
        start = 1'b0;
        byte_ready = 1'b0;
        if (got < nb) begin
            chk({tag, "_timeout_bytes"}, 32'(got), 32'(nb));
            return;
        end
        chk({tag, "_busy_held"}, 32'(bad_busy), 32'd0);
        chk({tag, "_no_err_midframe"}, 32'(bad_err), 32'd0);
        chk({tag, "_no_early_done"}, 32'(bad_done), 32'd0);
        chk({tag, "_done_pulse"}, 32'(done), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        chk({tag, "_valid_off_at_done"}, 32'(byte_valid), 32'd0);
        chk({tag, "_decode_rem_zero"}, 32'(poly_mod(64'(coll >> (32 - t)), t, k_g(k), k_r(k))), 32'd0);
        tick();
        chk({tag, "_done_cleared"}, 32'(done), 32'd0);
        chk({tag, "_busy_cleared"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        int w;
        logic bad;
        logic [1:0] rk;
        logic [19:0] rd;

        vecs[0] = '{k: 2'd0, d: 20'h00001, exp_cw: 32'h01300000, mode: 0};
        vecs[1] = '{k: 2'd1, d: 20'h00001, exp_cw: 32'h00010700, mode: 0};
        vecs[2] = '{k: 2'd1, d: 20'h00000, exp_cw: 32'h00000000, mode: 0};
        vecs[3] = '{k: 2'd3, d: 20'h00001, exp_cw: 32'h000018CC, mode: 1};
        vecs[4] = '{k: 2'd0, d: 20'hFFF01, exp_cw: 32'h01300000, mode: 0};
        vecs[5] = '{k: 2'd1, d: 20'h00001, exp_cw: 32'h00010700, mode: 2};

        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_byte_out", 32'(byte_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_kind", 32'(err_kind), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_frame(vecs[i].k, vecs[i].d, vecs[i].exp_cw, vecs[i].mode, $sformatf("vec%0d", i));
        end

        // Illegal kind: one err_kind pulse, nothing else moves.
        start = 1'b1; kind = 2'd2; data = 20'($urandom);
        tick();
        start = 1'b0;
        chk("err_pulse", 32'(err_kind), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_valid", 32'(byte_valid), 32'd0);
        chk("err_done", 32'(done), 32'd0);
        tick();
        chk("err_pulse_cleared", 32'(err_kind), 32'd0);
        chk("err_busy_after", 32'(busy), 32'd0);

        // Reset after the first byte of a kind1 frame aborts it.
        start = 1'b1; kind = 2'd1; data = 20'h0ABCD; byte_ready = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (byte_valid !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        chk("abort_first_valid", 32'(byte_valid), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(byte_valid), 32'd0);
        chk("abort_byte_out", 32'(byte_out), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (byte_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("abort_no_more_bytes", 32'(bad), 32'd0);
        byte_ready = 1'b0;
        do_frame(2'd0, 20'h00001, 32'h01300000, 0, "post_rst");

        for (int i = 0; i < 24; i++) begin
            case ($urandom % 3)
                0:       rk = 2'd0;
                1:       rk = 2'd1;
                default: rk = 2'd3;
            endcase
            rd = 20'($urandom);
            do_frame(rk, rd, model_cw(rk, rd), int'($urandom % 3), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
